// File: rtl/frogger_pkg.sv
// Shared Frogger constants: FSM state encodings, playfield geometry and game defaults.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_RUNNING   = 3'b001,
    ST_HIT       = 3'b010,
    ST_SCORED    = 3'b011,
    ST_GAME_OVER = 3'b100
  } state_t;

  localparam int TILE_SIZE           = 32;
  localparam int GRID_COLS           = 14;
  localparam int GRID_ROWS           = 13;
  localparam int DEFAULT_GOAL_ROW    = 0;
  localparam int DEFAULT_START_LIVES = 3;

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter (00..99) with synchronous clear, increment enable and saturation at 99.
module bcd_counter_2d (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Clr,
  input  logic       i_Inc,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones
);

  logic [3:0] tens;
  logic [3:0] ones;

  function automatic logic [7:0] bcd_sat_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd9 && o == 4'd9) return {t, o};
    if (o == 4'd9)              return {t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (i_Clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (i_Inc) begin
      {tens, ones} <= bcd_sat_inc(tens, ones);
    end
  end

  assign o_Tens = tens;
  assign o_Ones = ones;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger round/lives sequencer: drives game-active enable, respawn pulse, lives, countdown and BCD score.
module game_state_ctrl
  import frogger_pkg::*;
#(
  parameter int c_START_LIVES    = DEFAULT_START_LIVES,
  parameter int c_GOAL_ROW       = DEFAULT_GOAL_ROW,
  parameter int c_FRAMES_PER_SEC = 60,
  parameter int c_ROUND_SECONDS  = 60,
  parameter int c_HOLD_FRAMES    = 60,
  parameter int c_SCORE_LIMIT    = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Game_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic       o_Game_Active,
  output logic       o_Frog_Reset,
  output logic [2:0] o_State,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Time_Left,
  output logic [3:0] o_Score_Tens,
  output logic [3:0] o_Score_Ones
);

  localparam int FW = $clog2(c_FRAMES_PER_SEC + 1);
  localparam int HW = $clog2(c_HOLD_FRAMES + 1);

  state_t        state, state_nxt;
  logic [1:0]    lives, lives_nxt;
  logic [6:0]    time_left, time_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          game_active, frog_reset, frog_reset_nxt;
  logic          score_clr, score_inc, score_at_limit, hold_done;
  logic [3:0]    score_tens, score_ones;
  logic [6:0]    score_bin;

  function automatic logic [1:0] sat_dec_lives(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  bcd_counter_2d u_score (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Clr  (score_clr),
    .i_Inc  (score_inc),
    .o_Tens (score_tens),
    .o_Ones (score_ones)
  );

  assign score_bin      = {3'b000, score_tens} * 7'd10 + {3'b000, score_ones};
  assign score_at_limit = (score_bin >= 7'(c_SCORE_LIMIT));
  assign hold_done      = i_Frame_Tick && (hold_cnt == HW'(c_HOLD_FRAMES - 1));

  always_comb begin
    state_nxt      = state;
    lives_nxt      = lives;
    time_nxt       = time_left;
    frame_nxt      = frame_cnt;
    hold_nxt       = hold_cnt;
    frog_reset_nxt = 1'b0;
    score_clr      = 1'b0;
    score_inc      = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_Game_Start) begin
          state_nxt      = ST_RUNNING;
          lives_nxt      = 2'(c_START_LIVES);
          time_nxt       = 7'(c_ROUND_SECONDS);
          frame_nxt      = '0;
          score_clr      = 1'b1;
          frog_reset_nxt = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (i_Collided) begin
          state_nxt = ST_HIT;
          lives_nxt = sat_dec_lives(lives);
          hold_nxt  = '0;
        end else if (i_Frogger_Y == 6'(c_GOAL_ROW)) begin
          state_nxt = ST_SCORED;
          score_inc = 1'b1;
          hold_nxt  = '0;
        end else if (i_Frame_Tick) begin
          if (frame_cnt == FW'(c_FRAMES_PER_SEC - 1)) begin
            frame_nxt = '0;
            time_nxt  = time_left - 7'd1;
            // The countdown expiring costs a life exactly like a collision.
            if (time_left == 7'd1) begin
              state_nxt = ST_HIT;
              lives_nxt = sat_dec_lives(lives);
              hold_nxt  = '0;
            end
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end
      end
      ST_HIT, ST_SCORED: begin
        if (state == ST_SCORED && score_at_limit) begin
          state_nxt = ST_GAME_OVER;
        end else if (hold_done) begin
          if (state == ST_HIT && lives == 2'd0) begin
            state_nxt = ST_GAME_OVER;
          end else begin
            state_nxt      = ST_RUNNING;
            time_nxt       = 7'(c_ROUND_SECONDS);
            frame_nxt      = '0;
            frog_reset_nxt = 1'b1;
          end
        end else if (i_Frame_Tick) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      lives       <= 2'(c_START_LIVES);
      time_left   <= 7'(c_ROUND_SECONDS);
      frame_cnt   <= '0;
      hold_cnt    <= '0;
      game_active <= 1'b0;
      frog_reset  <= 1'b0;
    end else begin
      state       <= state_nxt;
      lives       <= lives_nxt;
      time_left   <= time_nxt;
      frame_cnt   <= frame_nxt;
      hold_cnt    <= hold_nxt;
      game_active <= (state_nxt == ST_RUNNING);
      frog_reset  <= frog_reset_nxt;
    end
  end

  assign o_Game_Active = game_active;
  assign o_Frog_Reset  = frog_reset;
  assign o_State       = state;
  assign o_Lives       = lives;
  assign o_Time_Left   = time_left;
  assign o_Score_Tens  = score_tens;
  assign o_Score_Ones  = score_ones;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed vector table, hand-written corner sequences, randomized run vs a model.
module tb_game_state_ctrl;

  localparam int LIVES = 3;
  localparam int FPS   = 4;
  localparam int ROUND = 3;
  localparam int HOLD  = 2;
  localparam int LIMIT = 11;
  localparam int GOAL  = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_SCORED = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, tick, coll;
  logic [5:0] y;
  logic       active, frog_reset;
  logic [2:0] st;
  logic [1:0] lives;
  logic [6:0] time_left;
  logic [3:0] tens, ones;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mode, m_lives, m_frames, m_holds, m_score, m_pulse;

  typedef struct {
    int s, t, c, y;
    int st, act, fr, lv, tm, sc;
  } vec_t;

  vec_t tbl[25];

  game_state_ctrl #(
    .c_START_LIVES   (LIVES),
    .c_GOAL_ROW      (GOAL),
    .c_FRAMES_PER_SEC(FPS),
    .c_ROUND_SECONDS (ROUND),
    .c_HOLD_FRAMES   (HOLD),
    .c_SCORE_LIMIT   (LIMIT)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Game_Start (start),
    .i_Frame_Tick (tick),
    .i_Collided   (coll),
    .i_Frogger_Y  (y),
    .o_Game_Active(active),
    .o_Frog_Reset (frog_reset),
    .o_State      (st),
    .o_Lives      (lives),
    .o_Time_Left  (time_left),
    .o_Score_Tens (tens),
    .o_Score_Ones (ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_st, input int e_act, input int e_fr,
                         input int e_lv, input int e_tm, input int e_sc);
    chk({tag, "_state"}, int'(st), e_st);
    chk({tag, "_active"}, int'(active), e_act);
    chk({tag, "_frog_reset"}, int'(frog_reset), e_fr);
    chk({tag, "_lives"}, int'(lives), e_lv);
    chk({tag, "_time"}, int'(time_left), e_tm);
    chk({tag, "_tens"}, int'(tens), e_sc / 10);
    chk({tag, "_ones"}, int'(ones), e_sc % 10);
  endtask

  task automatic step(input int s, input int t, input int c, input int yy);
    start = s[0];
    tick  = t[0];
    coll  = c[0];
    y     = 6'(yy);
    @(posedge clk);
    #1;
  endtask

  task automatic score_once();
    step(0, 0, 0, GOAL);
    step(0, 1, 0, 5);
    step(0, 1, 0, 5);
  endtask

  // Reference model: time kept as frames elapsed in the round, score as a plain integer.
  task automatic model_reset();
    m_mode = M_IDLE; m_lives = LIVES; m_frames = 0; m_holds = 0; m_score = 0; m_pulse = 0;
  endtask

  task automatic model_lose_life();
    m_mode  = M_HIT;
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    m_holds = 0;
  endtask

  task automatic model_step(input int s, input int t, input int c, input int yy);
    m_pulse = 0;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (s != 0) begin
        m_mode = M_RUN; m_lives = LIVES; m_frames = 0; m_score = 0; m_pulse = 1;
      end
    end else if (m_mode == M_RUN) begin
      if (c != 0) model_lose_life();
      else if (yy == GOAL) begin
        m_score = (m_score < 99) ? m_score + 1 : 99;
        m_mode  = M_SCORED;
        m_holds = 0;
      end else if (t != 0) begin
        m_frames++;
        if (m_frames == ROUND * FPS) model_lose_life();
      end
    end else if (m_mode == M_SCORED && m_score >= LIMIT) begin
      m_mode = M_OVER;
    end else if (t != 0) begin
      m_holds++;
      if (m_holds == HOLD) begin
        if (m_mode == M_HIT && m_lives == 0) m_mode = M_OVER;
        else begin
          m_mode = M_RUN; m_frames = 0; m_pulse = 1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; coll = 1'b0; y = 6'd5;
    tbl = '{
      '{1,0,0,5, 1,1,1,3,3,0}, '{1,0,0,5, 1,1,0,3,3,0}, '{0,1,0,5, 1,1,0,3,3,0},
      '{0,1,0,5, 1,1,0,3,3,0}, '{0,1,0,5, 1,1,0,3,3,0}, '{0,1,0,5, 1,1,0,3,2,0},
      '{0,1,0,5, 1,1,0,3,2,0}, '{0,1,0,5, 1,1,0,3,2,0}, '{0,1,0,5, 1,1,0,3,2,0},
      '{0,1,0,5, 1,1,0,3,1,0}, '{0,1,0,5, 1,1,0,3,1,0}, '{0,1,0,5, 1,1,0,3,1,0},
      '{0,1,0,5, 1,1,0,3,1,0}, '{0,1,0,5, 2,0,0,2,0,0}, '{0,1,0,5, 2,0,0,2,0,0},
      '{0,1,0,5, 1,1,1,2,3,0}, '{0,0,0,5, 1,1,0,2,3,0}, '{0,0,1,0, 2,0,0,1,3,0},
      '{0,0,1,0, 2,0,0,1,3,0}, '{0,1,1,0, 2,0,0,1,3,0}, '{0,1,0,5, 1,1,1,1,3,0},
      '{0,0,0,0, 3,0,0,1,3,1}, '{0,1,0,5, 3,0,0,1,3,1}, '{0,1,0,5, 1,1,1,1,3,1},
      '{0,1,0,5, 1,1,0,1,3,1}
    };

    #12;
    chk_all("reset", M_IDLE, 0, 0, LIVES, ROUND, 0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].s, tbl[i].t, tbl[i].c, tbl[i].y);
      chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].act, tbl[i].fr, tbl[i].lv, tbl[i].tm, tbl[i].sc);
    end

    // Last life lost: game over keeps the score and ignores play inputs.
    step(0, 0, 1, 5);
    chk_all("lastlife_hit", M_HIT, 0, 0, 0, 3, 1);
    step(0, 1, 0, 5);
    step(0, 1, 0, 5);
    chk_all("lastlife_over", M_OVER, 0, 0, 0, 3, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, GOAL);
    chk_all("over_hold", M_OVER, 0, 0, 0, 3, 1);
    step(1, 0, 0, 5);
    chk_all("restart", M_RUN, 1, 1, 3, 3, 0);

    // Three collisions from a full set of lives.
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1, 5);
      chk_all($sformatf("coll%0d_hit", k), M_HIT, 0, 0, 3 - k, 3, 0);
      step(0, 1, 0, 5);
      step(0, 1, 0, 5);
      if (k < 3) chk_all($sformatf("coll%0d_back", k), M_RUN, 1, 1, 3 - k, 3, 0);
      else       chk_all("coll3_over", M_OVER, 0, 0, 0, 3, 0);
    end

    // Score carry 09 -> 10, then the limit of 11 ends the game.
    step(1, 0, 0, 5);
    for (int k = 1; k <= 10; k++) score_once();
    chk_all("score10", M_RUN, 1, 1, 3, 3, 10);
    step(0, 0, 0, GOAL);
    chk_all("score11", M_SCORED, 0, 0, 3, 3, 11);
    step(0, 1, 0, 5);
    chk_all("limit_over", M_OVER, 0, 0, 3, 3, 11);

    // Asynchronous reset in the middle of a hit, between clock edges.
    step(1, 0, 0, 5);
    step(0, 1, 1, 5);
    chk_all("pre_async", M_HIT, 0, 0, 2, 3, 0);
    start = 1'b0; tick = 1'b0; coll = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", M_IDLE, 0, 0, LIVES, ROUND, 0);
    #1;
    rst = 1'b0;

    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int s, t, c, yy;
      bit quiet;
      quiet = ((n / 150) % 2) == 1;
      s  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      t  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      c  = (!quiet && $urandom_range(0, 24) == 0) ? 1 : 0;
      yy = (!quiet && $urandom_range(0, 19) == 0) ? GOAL : int'($urandom_range(1, 12));
      step(s, t, c, yy);
      model_step(s, t, c, yy);
      chk_all($sformatf("rnd%0d", n), m_mode, (m_mode == M_RUN) ? 1 : 0, m_pulse, m_lives,
              ROUND - m_frames / FPS, m_score);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
